calc_entry_sequencer: RTL and testbench

//  Top-level sequencer for the calculator keypad path: takes debounced key events, builds operand A, the operator and operand B.

---
 rtl/calc_pkg.sv | 51 +++++
 rtl/digit_accumulator.sv | 80 ++++++++
 rtl/calc_entry_sequencer.sv | 175 +++++++++++++++++
 tb/tb_calc_entry_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared key codes, ALU opcode and sequencer state types for the
//            calculator entry path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam logic [3:0] C_KEY_ADD  = 4'hA;
    localparam logic [3:0] C_KEY_SUB  = 4'hB;
    localparam logic [3:0] C_KEY_MUL  = 4'hC;
    localparam logic [3:0] C_KEY_EQ   = 4'hD;
    localparam logic [3:0] C_KEY_CLR  = 4'hE;
    localparam logic [3:0] C_KEY_BKSP = 4'hF;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        S_OPA    = 3'd0,
        S_OPB    = 3'd1,
        S_EXEC   = 3'd2,
        S_RESULT = 3'd3,
        S_ERR    = 3'd4
    } statetype;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic alu_op_t key_to_op(input logic [3:0] k);
        case (k)
            C_KEY_SUB: return ALU_SUB;
            C_KEY_MUL: return ALU_MUL;
            default:   return ALU_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_accumulator.sv
// ============================================================================
// Module   : digit_accumulator
// Purpose  : Decimal operand accumulator with digit counter. Optional
//            backspace divide is built only when CALC_BACKSPACE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_accumulator #(
    parameter int WIDTH          = 16,
    parameter int MAX_CHARACTERS = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load,
    input  logic [WIDTH-1:0]                    load_value,
    input  logic                                clear,
    input  logic                                push_digit,
    input  logic [3:0]                          digit,
    input  logic                                pop_digit,
    output logic [WIDTH-1:0]                    value,
    output logic [$clog2(MAX_CHARACTERS+1)-1:0] count,
    output logic                                full
);

    localparam int CW = $clog2(MAX_CHARACTERS + 1);

    logic [WIDTH-1:0] r_value;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_base_value;
    logic [WIDTH-1:0] w_next_value;
    logic [CW-1:0]    w_base_count;
    logic [CW-1:0]    w_next_count;

    // clear together with push means "start a fresh operand with this digit"
    always_comb begin
        w_base_value = clear ? '0 : r_value;
        w_base_count = clear ? '0 : r_count;
        w_next_value = w_base_value;
        w_next_count = w_base_count;
        if (load) begin
            w_next_value = load_value;
            w_next_count = '0;
        end else if (push_digit) begin
            if ((w_base_count < CW'(MAX_CHARACTERS)) &&
                !(digit == 4'd0 && w_base_value == '0 && w_base_count == '0)) begin
                w_next_value = w_base_value * WIDTH'(10) + WIDTH'(digit);
                w_next_count = w_base_count + CW'(1);
            end
        end
`ifdef CALC_BACKSPACE_EN
        else if (pop_digit && w_base_count != '0) begin
            w_next_value = w_base_value / WIDTH'(10);
            w_next_count = w_base_count - CW'(1);
        end
`endif
    end

`ifndef CALC_BACKSPACE_EN
    logic w_unused_pop;
    assign w_unused_pop = pop_digit;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_count <= '0;
        end else begin
            r_value <= w_next_value;
            r_count <= w_next_count;
        end
    end

    assign value = r_value;
    assign count = r_count;
    assign full  = (r_count == CW'(MAX_CHARACTERS));

endmodule

`default_nettype wire

// File: rtl/calc_entry_sequencer.sv
// ============================================================================
// Module   : calc_entry_sequencer
// Purpose  : Keypad-to-ALU sequencer: builds A, op, B, runs the ALU handshake
//            and holds result/error for display. Macro: CALC_BACKSPACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_entry_sequencer #(
    parameter int MAX_CHARACTERS = 4,
    parameter int WIDTH          = 16,
    parameter int ALU_TIMEOUT    = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                key_valid,
    input  logic [3:0]                          key_code,
    output logic                                alu_start,
    output logic [1:0]                          alu_op,
    output logic [WIDTH-1:0]                    alu_a,
    output logic [WIDTH-1:0]                    alu_b,
    input  logic                                alu_done,
    input  logic [WIDTH-1:0]                    alu_result,
    input  logic                                alu_overflow,
    output logic [WIDTH-1:0]                    disp_value,
    output logic [$clog2(MAX_CHARACTERS+1)-1:0] disp_digits,
    output logic                                busy,
    output logic                                error
);

    import calc_pkg::*;

    localparam int               CW          = $clog2(MAX_CHARACTERS + 1);
    localparam int               TW          = $clog2(ALU_TIMEOUT + 1);
    localparam logic [WIDTH-1:0] C_MAX_VALUE = WIDTH'(pow10(MAX_CHARACTERS) - 1);

    statetype         r_state;
    alu_op_t          r_op;
    alu_op_t          r_alu_op;
    logic             r_alu_start;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [TW-1:0]    r_timer;

    logic w_key_digit, w_key_op, w_key_eq, w_key_clr, w_key_bksp, w_result_ok;
    logic w_clear_a, w_push_a, w_load_a, w_pop_a;
    logic w_clear_b, w_push_b, w_pop_b;
    logic [WIDTH-1:0] w_value_a, w_value_b;
    logic [CW-1:0]    w_count_a, w_count_b;
    logic             w_full_a, w_full_b, w_unused_full;

    assign w_key_digit = key_valid && (key_code <= 4'd9);
    assign w_key_op    = key_valid && (key_code == C_KEY_ADD || key_code == C_KEY_SUB ||
                                       key_code == C_KEY_MUL);
    assign w_key_eq    = key_valid && (key_code == C_KEY_EQ);
    assign w_key_clr   = key_valid && (key_code == C_KEY_CLR);
    assign w_key_bksp  = key_valid && (key_code == C_KEY_BKSP);
    assign w_result_ok = !alu_overflow && (alu_result <= C_MAX_VALUE);

    // A digit after a result starts a new operand A from scratch
    assign w_clear_a = w_key_clr || (r_state == S_RESULT && w_key_digit);
    assign w_push_a  = (r_state == S_OPA || r_state == S_RESULT) && w_key_digit;
    assign w_load_a  = (r_state == S_EXEC) && alu_done && w_result_ok && !w_key_clr;
    assign w_clear_b = w_key_clr || ((r_state == S_OPA || r_state == S_RESULT) && w_key_op);
    assign w_push_b  = (r_state == S_OPB) && w_key_digit;
`ifdef CALC_BACKSPACE_EN
    assign w_pop_a   = (r_state == S_OPA) && w_key_bksp;
    assign w_pop_b   = (r_state == S_OPB) && w_key_bksp;
`else
    assign w_pop_a   = 1'b0;
    assign w_pop_b   = 1'b0;
`endif
    assign w_unused_full = w_full_a ^ w_full_b ^ w_key_bksp;

    digit_accumulator #(.WIDTH(WIDTH), .MAX_CHARACTERS(MAX_CHARACTERS)) u_acc_a (
        .clk(clk), .reset(reset), .load(w_load_a), .load_value(alu_result),
        .clear(w_clear_a), .push_digit(w_push_a), .digit(key_code), .pop_digit(w_pop_a),
        .value(w_value_a), .count(w_count_a), .full(w_full_a)
    );

    digit_accumulator #(.WIDTH(WIDTH), .MAX_CHARACTERS(MAX_CHARACTERS)) u_acc_b (
        .clk(clk), .reset(reset), .load(1'b0), .load_value({WIDTH{1'b0}}),
        .clear(w_clear_b), .push_digit(w_push_b), .digit(key_code), .pop_digit(w_pop_b),
        .value(w_value_b), .count(w_count_b), .full(w_full_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_OPA;
            r_op        <= ALU_ADD;
            r_alu_op    <= ALU_ADD;
            r_alu_start <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_timer     <= '0;
        end else begin
            r_alu_start <= 1'b0;
            if (w_key_clr) begin
                r_state <= S_OPA;
                r_timer <= '0;
            end else begin
                case (r_state)
                    S_OPA: begin
                        if (w_key_op) begin
                            r_op    <= key_to_op(key_code);
                            r_state <= S_OPB;
                        end
                    end
                    S_OPB: begin
                        if (w_key_op && w_count_b == '0) begin
                            r_op <= key_to_op(key_code);
                        end else if (w_key_eq && w_count_b != '0) begin
                            r_alu_a     <= w_value_a;
                            r_alu_b     <= w_value_b;
                            r_alu_op    <= r_op;
                            r_alu_start <= 1'b1;
                            r_timer     <= '0;
                            r_state     <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        r_timer <= r_timer + TW'(1);
                        if (alu_done) begin
                            r_state <= w_result_ok ? S_RESULT : S_ERR;
                        end else if (r_timer == TW'(ALU_TIMEOUT - 1)) begin
                            r_state <= S_ERR;
                        end
                    end
                    S_RESULT: begin
                        if (w_key_digit) begin
                            r_state <= S_OPA;
                        end else if (w_key_op) begin
                            r_op    <= key_to_op(key_code);
                            r_state <= S_OPB;
                        end
                    end
                    S_ERR: begin
                    end
                    default: r_state <= S_OPA;
                endcase
            end
        end
    end

    always_comb begin
        disp_value  = '0;
        disp_digits = '0;
        case (r_state)
            S_OPA, S_RESULT: begin
                disp_value  = w_value_a;
                disp_digits = w_count_a;
            end
            S_OPB: begin
                disp_value  = (w_count_b != '0) ? w_value_b : w_value_a;
                disp_digits = w_count_b;
            end
            S_EXEC: begin
                disp_value  = w_value_b;
                disp_digits = w_count_b;
            end
            default: begin
            end
        endcase
    end

    assign alu_start = r_alu_start;
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign busy      = (r_state == S_EXEC);
    assign error     = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_calc_entry_sequencer.sv
// ============================================================================
// Module   : tb_calc_entry_sequencer
// Purpose  : Directed plus randomized key streams for calc_entry_sequencer,
//            checked against an operand-level calculator model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_entry_sequencer;

    localparam int MAXC = 4;
    localparam int W    = 16;
    localparam int TMO  = 255;
    localparam int MAXV = 9999;

    localparam int K_ADD = 10, K_SUB = 11, K_MUL = 12, K_EQ = 13, K_CLR = 14, K_BS = 15;
    localparam int P_OPA = 0, P_OPB = 1, P_EXEC = 2, P_RESULT = 3, P_ERR = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         alu_start;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_result, disp_value;
    logic         alu_done, alu_overflow, busy, error;
    logic [2:0]   disp_digits;

    calc_entry_sequencer #(.MAX_CHARACTERS(MAXC), .WIDTH(W), .ALU_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .disp_value(disp_value), .disp_digits(disp_digits), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: phase, operand values/digit counts, latched operator
    int ph, ma, ca, mb, cb, mop;
    int alu_lat;
    bit alu_badrange;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_disp();
        case (ph)
            P_OPA, P_RESULT: return ma;
            P_OPB:           return (cb > 0) ? mb : ma;
            P_EXEC:          return mb;
            default:         return 0;
        endcase
    endfunction

    function automatic int exp_digits();
        case (ph)
            P_OPA, P_RESULT: return ca;
            P_OPB, P_EXEC:   return cb;
            default:         return 0;
        endcase
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".disp"}, disp_value, exp_disp());
        check({tag, ".digits"}, disp_digits, exp_digits());
        check({tag, ".busy"}, busy, (ph == P_EXEC));
        check({tag, ".error"}, error, (ph == P_ERR));
    endtask

    task automatic model_reset();
        ph = P_OPA; ma = 0; ca = 0; mb = 0; cb = 0; mop = 0;
    endtask

    task automatic model_key(input int k);
        bit is_op;
        is_op = (k >= K_ADD && k <= K_MUL);
        if (k == K_CLR) begin
            model_reset();
            return;
        end
        case (ph)
            P_OPA: begin
                if (k <= 9) begin
                    if (ca < MAXC && !(k == 0 && ca == 0)) begin ma = ma * 10 + k; ca++; end
                end else if (is_op) begin
                    mop = k - K_ADD; mb = 0; cb = 0; ph = P_OPB;
                end
`ifdef CALC_BACKSPACE_EN
                else if (k == K_BS && ca > 0) begin ma = ma / 10; ca--; end
`endif
            end
            P_OPB: begin
                if (k <= 9) begin
                    if (cb < MAXC && !(k == 0 && cb == 0)) begin mb = mb * 10 + k; cb++; end
                end else if (is_op) begin
                    if (cb == 0) mop = k - K_ADD;
                end
`ifdef CALC_BACKSPACE_EN
                else if (k == K_BS && cb > 0) begin mb = mb / 10; cb--; end
`endif
            end
            P_RESULT: begin
                if (k <= 9) begin
                    ma = k; ca = (k != 0) ? 1 : 0; ph = P_OPA;
                end else if (is_op) begin
                    mop = k - K_ADD; mb = 0; cb = 0; ph = P_OPB;
                end
            end
            default: begin
            end
        endcase
    endtask

    // Called right after the edge that sampled '='; plays the ALU side
    task automatic run_exec();
        int tr, nk;
        bit ovf, ok;
        logic [W-1:0] res;
        check("exec.alu_start", alu_start, 1);
        check("exec.alu_a", alu_a, ma);
        check("exec.alu_b", alu_b, mb);
        check("exec.alu_op", alu_op, mop);
        ph = P_EXEC;
        check_state("exec.entry");
        case (mop)
            0:       tr = ma + mb;
            1:       tr = ma - mb;
            default: tr = ma * mb;
        endcase
        if (alu_lat < 0) return;
        if (alu_lat == 0) begin
            tick();
            check("timeout.start_low", alu_start, 0);
            repeat (TMO - 2) tick();
            check("timeout.pre_error", error, 0);
            check("timeout.pre_busy", busy, 1);
            tick();
            ph = P_ERR;
            check_state("timeout.hit");
            return;
        end
        for (int i = 1; i < alu_lat; i++) begin
            nk = $urandom_range(0, 14);
            if (nk == K_CLR) nk = K_BS;
            key_valid = 1'b1;
            key_code  = 4'(nk);
            tick();
            key_valid = 1'b0;
            check("exec.wait_start", alu_start, 0);
            check_state("exec.wait");
        end
        ovf = (tr < 0) || (tr > MAXV);
        res = W'(tr);
        ok  = !ovf;
        if (alu_badrange && !ovf) begin
            res = W'(MAXV + 1 + $urandom_range(0, 1000));
            ok  = 1'b0;
        end
        alu_done     = 1'b1;
        alu_result   = res;
        alu_overflow = ovf;
        tick();
        alu_done     = 1'b0;
        alu_overflow = 1'b0;
        if (ok) begin
            ma = tr; ca = 0; ph = P_RESULT;
        end else begin
            ph = P_ERR;
        end
        check_state("exec.done");
        check("exec.done_start", alu_start, 0);
    endtask

    task automatic press(input int k);
        key_valid = 1'b1;
        key_code  = 4'(k);
        tick();
        key_valid = 1'b0;
        if (k == K_EQ && ph == P_OPB && cb > 0) begin
            run_exec();
        end else begin
            model_key(k);
            check_state("key");
            check("key.alu_start", alu_start, 0);
        end
    endtask

    initial begin
        int r;
        reset = 1'b1; key_valid = 1'b0; key_code = 4'd0;
        alu_done = 1'b0; alu_result = '0; alu_overflow = 1'b0;
        alu_lat = 3; alu_badrange = 1'b0;
        model_reset();
        tick(); tick();
        check("rst.alu_start", alu_start, 0);
        check("rst.alu_a", alu_a, 0);
        check("rst.alu_b", alu_b, 0);
        check("rst.alu_op", alu_op, 0);
        check_state("rst");
        reset = 1'b0;
        tick();

        // 12 + 34, ALU answers on the third busy cycle
        press(1); press(2); press(K_ADD); press(3); press(4);
        alu_lat = 3; press(K_EQ);
        check("t1.result", disp_value, 46);

        // fifth digit dropped
        press(K_CLR);
        press(1); press(2); press(3); press(4); press(5);
        check("t2.value", disp_value, 1234);
        check("t2.digits", disp_digits, 4);

        // key_valid low: code must be ignored
        key_code = 4'd7; tick();
        check_state("novalid");

        // overflow path
        press(K_CLR);
        repeat (4) press(9);
        press(K_MUL);
        repeat (4) press(9);
        alu_lat = 2; press(K_EQ);
        check("t3.error", error, 1);
        press(7);
        check("t3.ignored", disp_value, 0);
        press(K_CLR);
        check("t3.cleared", error, 0);

        // timeout, then a stray done
        press(5); press(K_SUB); press(3);
        alu_lat = 0; press(K_EQ);
        alu_done = 1'b1; alu_result = W'(2); tick(); alu_done = 1'b0;
        check_state("t4.late_done");
        press(K_CLR);

        // clear in the same cycle as done
        press(2); press(K_ADD); press(3);
        alu_lat = -1; press(K_EQ);
        tick();
        check("t5.busy", busy, 1);
        key_valid = 1'b1; key_code = 4'(K_CLR);
        alu_done = 1'b1; alu_result = W'(5);
        tick();
        key_valid = 1'b0; alu_done = 1'b0;
        model_reset();
        check_state("t5.clr_beats_done");
        tick();
        check("t5.no_start", alu_start, 0);

        // reset during execution
        press(4); press(K_MUL); press(6);
        alu_lat = -1; press(K_EQ);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        model_reset();
        check_state("t5.reset_exec");
        check("t5.reset_alu_a", alu_a, 0);
        alu_done = 1'b1; alu_result = W'(24); tick(); alu_done = 1'b0;
        check_state("t5.reset_late_done");
        check("t5.reset_no_start", alu_start, 0);

        // backspace
        press(1); press(2); press(3); press(K_BS);
`ifdef CALC_BACKSPACE_EN
        check("t6.value", disp_value, 12);
        check("t6.digits", disp_digits, 2);
`else
        check("t6.value", disp_value, 123);
        check("t6.digits", disp_digits, 3);
`endif

        // randomized key stream
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            alu_lat      = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 4);
            alu_badrange = ($urandom_range(0, 7) == 0);
            if (r < 55)      press($urandom_range(0, 9));
            else if (r < 70) press($urandom_range(K_ADD, K_MUL));
            else if (r < 85) press(K_EQ);
            else if (r < 89) press(K_CLR);
            else if (r < 95) press(K_BS);
            else begin
                key_code = 4'($urandom_range(0, 15));
                tick();
                check_state("rnd.novalid");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
